pipe_stage_reg: RTL

//  Generic RISC-V pipeline stage register (IF/ID, ID/EX, EX/MEM, MEM/WB) with a

---
 rtl/riscv_pipe_pkg.sv | 44 ++++
 rtl/pipe_stage_reg.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/riscv_pipe_pkg.sv
// Shared definitions for RISC-V pipeline stage registers: per-stage bundle widths,
// ID/EX control field offsets, bubble control values and the stage-register state encoding.
package riscv_pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } pipe_state_e;

    // IF/ID: Instr, PC, PCPlus4
    localparam int unsigned IFID_CTRL_W  = 1;
    localparam int unsigned IFID_DATA_W  = 96;

    // ID/EX: RD1, RD2, PC, Rs1, Rs2, Rd, ImmExt, PCPlus4
    localparam int unsigned IDEX_CTRL_W  = 14;
    localparam int unsigned IDEX_DATA_W  = 175;

    // EX/MEM: ALUResult, WriteData, Rd, PCPlus4
    localparam int unsigned EXMEM_CTRL_W = 4;
    localparam int unsigned EXMEM_DATA_W = 101;

    // MEM/WB: ALUResult, ReadData, Rd, PCPlus4
    localparam int unsigned MEMWB_CTRL_W = 3;
    localparam int unsigned MEMWB_DATA_W = 101;

    // ID/EX control bundle bit offsets (LSB of each field)
    localparam int unsigned IDEX_REGWRITE   = 13;
    localparam int unsigned IDEX_MEMWRITE   = 12;
    localparam int unsigned IDEX_JUMP       = 11;
    localparam int unsigned IDEX_BRANCH     = 10;
    localparam int unsigned IDEX_ALUSRCA    = 9;
    localparam int unsigned IDEX_ALUSRCB    = 7;
    localparam int unsigned IDEX_RESULTSRC  = 5;
    localparam int unsigned IDEX_ALUCONTROL = 1;
    localparam int unsigned IDEX_PCJALR     = 0;

    // Bubble control values: every write/branch enable deasserted
    localparam logic [IFID_CTRL_W-1:0]  IFID_CTRL_RST  = '0;
    localparam logic [IDEX_CTRL_W-1:0]  IDEX_CTRL_RST  = '0;
    localparam logic [EXMEM_CTRL_W-1:0] EXMEM_CTRL_RST = '0;
    localparam logic [MEMWB_CTRL_W-1:0] MEMWB_CTRL_RST = '0;

endpackage

// File: rtl/pipe_stage_reg.sv
// Generic pipeline stage register with valid/ready handshake, optional skid entry
// and synchronous flush that turns held and incoming entries into bubbles.
module pipe_stage_reg
    import riscv_pipe_pkg::*;
#(
    parameter int unsigned       CTRL_W     = 16,
    parameter int unsigned       DATA_W     = 154,
    parameter logic [CTRL_W-1:0] CTRL_RST   = '0,
    parameter bit                SKID_EN    = 1'b1,
    parameter bit                CLEAR_DATA = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occ
);

    pipe_state_e       state_q;
    logic              out_valid_q;
    logic [CTRL_W-1:0] main_ctrl_q;
    logic [DATA_W-1:0] main_data_q;
    logic [1:0]        occ_q;

    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data;

    logic accept;
    logic drain;
    logic skid_load;

    assign accept    = in_valid & in_ready & ~flush;
    assign drain     = out_valid_q & out_ready;
    assign skid_load = SKID_EN && (state_q == ST_FULL) && accept && !drain;

    // Main entry and occupancy state machine; flush wins over every transition
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_EMPTY;
            out_valid_q <= 1'b0;
            main_ctrl_q <= CTRL_RST;
            main_data_q <= '0;
            occ_q       <= 2'd0;
        end else if (flush) begin
            state_q     <= ST_EMPTY;
            out_valid_q <= 1'b0;
            main_ctrl_q <= CTRL_RST;
            occ_q       <= 2'd0;
            if (CLEAR_DATA) begin
                main_data_q <= '0;
            end
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        state_q     <= ST_FULL;
                        out_valid_q <= 1'b1;
                        main_ctrl_q <= in_ctrl;
                        main_data_q <= in_data;
                        occ_q       <= 2'd1;
                    end
                end
                ST_FULL: begin
                    if (accept && drain) begin
                        main_ctrl_q <= in_ctrl;
                        main_data_q <= in_data;
                    end else if (skid_load) begin
                        state_q <= ST_SKID;
                        occ_q   <= 2'd2;
                    end else if (drain) begin
                        state_q     <= ST_EMPTY;
                        out_valid_q <= 1'b0;
                        main_ctrl_q <= CTRL_RST;
                        occ_q       <= 2'd0;
                    end
                end
                ST_SKID: begin
                    if (drain) begin
                        state_q     <= ST_FULL;
                        main_ctrl_q <= skid_ctrl;
                        main_data_q <= skid_data;
                        occ_q       <= 2'd1;
                    end
                end
                default: begin
                    state_q     <= ST_EMPTY;
                    out_valid_q <= 1'b0;
                    main_ctrl_q <= CTRL_RST;
                    occ_q       <= 2'd0;
                end
            endcase
        end
    end

    if (SKID_EN) begin : g_skid
        logic [CTRL_W-1:0] skid_ctrl_q;
        logic [DATA_W-1:0] skid_data_q;
        logic              in_ready_q;

        // in_ready is registered: it drops only for the cycles the skid entry is occupied
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                skid_ctrl_q <= CTRL_RST;
                skid_data_q <= '0;
                in_ready_q  <= 1'b1;
            end else if (flush) begin
                skid_ctrl_q <= CTRL_RST;
                in_ready_q  <= 1'b1;
                if (CLEAR_DATA) begin
                    skid_data_q <= '0;
                end
            end else begin
                if (skid_load) begin
                    skid_ctrl_q <= in_ctrl;
                    skid_data_q <= in_data;
                end
                in_ready_q <= !(skid_load || ((state_q == ST_SKID) && !drain));
            end
        end

        assign skid_ctrl = skid_ctrl_q;
        assign skid_data = skid_data_q;
        assign in_ready  = in_ready_q;
    end else begin : g_no_skid
        assign skid_ctrl = CTRL_RST;
        assign skid_data = '0;
        assign in_ready  = ~out_valid_q | out_ready;
    end

    assign out_valid = out_valid_q;
    assign out_ctrl  = main_ctrl_q;
    assign out_data  = main_data_q;
    assign occ       = occ_q;

endmodule
